bj_unit: RTL
============

# bj_unit

Parametrised branch/jump resolution unit for the LA32R pipeline, sitting at the ID→EX boundary. It decodes the branch/jump opcode, compares operands and computes the target and link value. It detects front-end mispredictions and registers the result in one valid/ready pipeline stage. Optionally, it maintains a branch history table (BHT) of 2-bit counters that the fetch stage queries.

## Interface
- DATA_W, 32, datapath/PC width (≥32)
- BHT_DEPTH, 64, BHT entries, power of two ≥2
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  kill the stage register and the incoming instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  unit accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  DATA_W  instruction PC
- in_rj, in_rd  in  DATA_W  source operands
- in_pred_taken  in  1  front-end prediction
- in_pred_target  in  DATA_W  front-end predicted target
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_op  out  8  decoded op code (OP_* set, OP_INVALID for non-branch)
- out_taken  out  1  resolved direction
- out_target  out  DATA_W  resolved target
- out_redirect  out  1  misprediction, fetch must restart
- out_redirect_pc  out  DATA_W  restart PC
- out_link_we  out  1  link register write (BL→r1, JIRL→rd)
- out_link_data  out  DATA_W  in_pc+4 of that instruction
- fq_pc  in  DATA_W  fetch query PC
- fq_taken  out  1  BHT prediction for fq_pc

## Operation
- Decode on inst[31:26]: 010011 JIRL, 010100 B, 010101 BL, 010110 BEQ, 010111 BNE, 011000 BLT, 011001 BGE, 011010 BLTU, 011011 BGEU; all other codes → OP_INVALID.
- Offsets: offs16 = inst[25:10]; offs26 = {inst[9:0], inst[25:10]}. Both are shifted left 2 and sign-extended to DATA_W.
- Targets: B/BL = pc + offs26; conditional branches = pc + offs16; JIRL = rj + offs16. Additions wrap modulo 2^DATA_W.
- Direction: B/BL/JIRL are always taken. BEQ rj==rd; BNE rj!=rd; BLT/BGE signed; BLTU/BGEU unsigned. OP_INVALID: taken=0, target=pc+4, link_we=0.
- Redirect = (taken != pred_taken) | (taken & target != pred_target). redirect_pc = taken ? target : pc+4.
- A non-branch that was predicted taken therefore redirects to pc+4.
- BHT (BJ_BHT_EN):
  - Index = pc[log2(BHT_DEPTH)+1:2].
  - fq_taken = counter[idx(fq_pc)][1], a combinational read.
  - Update on output handshake (out_valid & out_ready & out_op!=OP_INVALID). The counter saturates up when taken, down when not.
  - An update and a query to the same index in the same cycle: the query returns the pre-update value (no bypass).

## Timing
- Latency 1 cycle: an input accepted at edge N appears on the outputs after edge N.
- in_ready = !out_valid | out_ready. A full skid is not required.
- flush is registered:
  - out_valid=0 after the edge.
  - The input is not captured that cycle.
  - No BHT update occurs for the flushed entry.
  - flush dominates a simultaneous load.
- All outputs are registered except in_ready and fq_taken. out_redirect is qualified by out_valid.
- Reset values: out_valid=0, out_op=OP_INVALID, out_taken=0, out_redirect=0, out_link_we=0, all data outputs 0, every BHT counter 2'b01.
- Reset asserted mid-operation drops the in-flight entry and reinitialises the BHT.
- Output payload holds stable while out_valid & !out_ready.

## Configuration
- BJ_BHT_EN defined: BHT storage and the update logic are present.
- BJ_BHT_EN undefined: no BHT storage, fq_taken is tied to 0, and fq_pc is unused. Resolution is unchanged.

## Structure
- The shared defs header holds OP_* codes (8-bit), opcode field constants and the BHT counter reset value.
- Sub-module bj_bht holds the counter array, read port and update port. It is instantiated only under BJ_BHT_EN.

## Test plan
- BEQ, pc=0x1C000000, rj=rd=5, offs16=4, pred_taken=0 → out_taken=1, target=0x1C000010, redirect=1, redirect_pc=0x1C000010.
- BLT rj=0xFFFFFFFF, rd=1 → taken. Same operands with BLTU → not taken. Pred not taken gives no redirect for BLTU.
- JIRL rd=r5, rj=0x1C001000, offs16=-1, pred_taken=1 with target 0x1C000FFC → no redirect, link_we=1, link_data=pc+4.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, payload stable, no BHT update. Next edge with out_ready=1 → second instruction accepted.
- flush asserted with in_valid=1 and out_valid=1 → out_valid=0 next cycle, input dropped, no counter change.
- BJ_BHT_EN: BNE at pc 0x100 resolves taken three times → counter 01→10→11→11, fq_taken(0x100)=1 from the cycle after the first update. Update and query at the same index in one cycle returns the old value.

Source files
------------

// File: rtl/bj_unit_pkg.sv
// Shared definitions for the branch/jump unit: op codes, opcode field values,
// BHT counter reset value and small decode/counter helpers.
package bj_unit_pkg;

    localparam logic [7:0] OP_INVALID = 8'h00;
    localparam logic [7:0] OP_JIRL    = 8'h01;
    localparam logic [7:0] OP_B       = 8'h02;
    localparam logic [7:0] OP_BL      = 8'h03;
    localparam logic [7:0] OP_BEQ     = 8'h04;
    localparam logic [7:0] OP_BNE     = 8'h05;
    localparam logic [7:0] OP_BLT     = 8'h06;
    localparam logic [7:0] OP_BGE     = 8'h07;
    localparam logic [7:0] OP_BLTU    = 8'h08;
    localparam logic [7:0] OP_BGEU    = 8'h09;

    localparam logic [5:0] OPC_JIRL = 6'b010011;
    localparam logic [5:0] OPC_B    = 6'b010100;
    localparam logic [5:0] OPC_BL   = 6'b010101;
    localparam logic [5:0] OPC_BEQ  = 6'b010110;
    localparam logic [5:0] OPC_BNE  = 6'b010111;
    localparam logic [5:0] OPC_BLT  = 6'b011000;
    localparam logic [5:0] OPC_BGE  = 6'b011001;
    localparam logic [5:0] OPC_BLTU = 6'b011010;
    localparam logic [5:0] OPC_BGEU = 6'b011011;

    localparam logic [1:0] BHT_CNT_RST = 2'b01;

    function automatic logic [7:0] decode_op(input logic [5:0] opc);
        logic [7:0] op;
        case (opc)
            OPC_JIRL: op = OP_JIRL;
            OPC_B:    op = OP_B;
            OPC_BL:   op = OP_BL;
            OPC_BEQ:  op = OP_BEQ;
            OPC_BNE:  op = OP_BNE;
            OPC_BLT:  op = OP_BLT;
            OPC_BGE:  op = OP_BGE;
            OPC_BLTU: op = OP_BLTU;
            OPC_BGEU: op = OP_BGEU;
            default:  op = OP_INVALID;
        endcase
        return op;
    endfunction

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? cnt : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? cnt : cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bj_bht.sv
// Branch history table of 2-bit saturating counters with one combinational
// query port and one update port; a same-cycle query sees the old value.
module bj_bht
    import bj_unit_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] q_idx,
    output logic             q_taken
);

    logic [1:0] cnt_r [BHT_DEPTH];

    // Counter array: weakly-not-taken at reset, saturating update on retire
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_r[i] <= BHT_CNT_RST;
            end
        end else if (upd_en) begin
            cnt_r[upd_idx] <= cnt_next(cnt_r[upd_idx], upd_taken);
        end
    end

    assign q_taken = cnt_r[q_idx][1];

endmodule

// File: rtl/bj_unit.sv
// Branch/jump resolution unit at the ID->EX boundary with a one-deep result
// register. Optional branch history table enabled by defining BJ_BHT_EN.
module bj_unit
    import bj_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rj,
    input  logic [DATA_W-1:0] in_rd,
    input  logic              in_pred_taken,
    input  logic [DATA_W-1:0] in_pred_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_op,
    output logic              out_taken,
    output logic [DATA_W-1:0] out_target,
    output logic              out_redirect,
    output logic [DATA_W-1:0] out_redirect_pc,
    output logic              out_link_we,
    output logic [DATA_W-1:0] out_link_data,
    input  logic [DATA_W-1:0] fq_pc,
    output logic              fq_taken
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(3'd4);

    logic [7:0]        op_s;
    logic              taken_s;
    logic              link_we_s;
    logic              redirect_s;
    logic              load_s;
    logic [DATA_W-1:0] offs16_s;
    logic [DATA_W-1:0] offs26_s;
    logic [DATA_W-1:0] pc4_s;
    logic [DATA_W-1:0] br_tgt_s;
    logic [DATA_W-1:0] jmp_tgt_s;
    logic [DATA_W-1:0] target_s;
    logic [DATA_W-1:0] redirect_pc_s;

    logic              valid_r;
    logic [7:0]        op_r;
    logic              taken_r;
    logic [DATA_W-1:0] target_r;
    logic              redirect_r;
    logic [DATA_W-1:0] redirect_pc_r;
    logic              link_we_r;
    logic [DATA_W-1:0] link_data_r;

    assign in_ready = !valid_r | out_ready;
    assign load_s   = in_valid & in_ready & !flush;

    assign offs16_s  = {{(DATA_W-18){in_inst[25]}}, in_inst[25:10], 2'b00};
    assign offs26_s  = {{(DATA_W-28){in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
    assign pc4_s     = in_pc + PC_STEP;
    assign br_tgt_s  = in_pc + offs16_s;
    assign jmp_tgt_s = in_pc + offs26_s;

    // Decode, operand compare and target selection for the incoming instruction
    always_comb begin
        op_s      = decode_op(in_inst[31:26]);
        taken_s   = 1'b0;
        target_s  = br_tgt_s;
        link_we_s = 1'b0;
        case (op_s)
            OP_JIRL: begin
                taken_s   = 1'b1;
                target_s  = in_rj + offs16_s;
                link_we_s = 1'b1;
            end
            OP_B: begin
                taken_s  = 1'b1;
                target_s = jmp_tgt_s;
            end
            OP_BL: begin
                taken_s   = 1'b1;
                target_s  = jmp_tgt_s;
                link_we_s = 1'b1;
            end
            OP_BEQ:  taken_s = (in_rj == in_rd);
            OP_BNE:  taken_s = (in_rj != in_rd);
            OP_BLT:  taken_s = ($signed(in_rj) <  $signed(in_rd));
            OP_BGE:  taken_s = ($signed(in_rj) >= $signed(in_rd));
            OP_BLTU: taken_s = (in_rj <  in_rd);
            OP_BGEU: taken_s = (in_rj >= in_rd);
            default: begin
                taken_s   = 1'b0;
                target_s  = pc4_s;
                link_we_s = 1'b0;
            end
        endcase
        if (taken_s) begin
            redirect_pc_s = target_s;
        end else begin
            redirect_pc_s = pc4_s;
        end
        redirect_s = (taken_s != in_pred_taken) | (taken_s & (target_s != in_pred_target));
    end

    // Result register; flush wins over load, redirect cleared whenever valid drops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r       <= 1'b0;
            op_r          <= OP_INVALID;
            taken_r       <= 1'b0;
            target_r      <= {DATA_W{1'b0}};
            redirect_r    <= 1'b0;
            redirect_pc_r <= {DATA_W{1'b0}};
            link_we_r     <= 1'b0;
            link_data_r   <= {DATA_W{1'b0}};
        end else if (flush) begin
            valid_r    <= 1'b0;
            redirect_r <= 1'b0;
        end else if (load_s) begin
            valid_r       <= 1'b1;
            op_r          <= op_s;
            taken_r       <= taken_s;
            target_r      <= target_s;
            redirect_r    <= redirect_s;
            redirect_pc_r <= redirect_pc_s;
            link_we_r     <= link_we_s;
            link_data_r   <= pc4_s;
        end else if (out_ready) begin
            valid_r    <= 1'b0;
            redirect_r <= 1'b0;
        end
    end

    assign out_valid       = valid_r;
    assign out_op          = op_r;
    assign out_taken       = taken_r;
    assign out_target      = target_r;
    assign out_redirect    = redirect_r;
    assign out_redirect_pc = redirect_pc_r;
    assign out_link_we     = link_we_r;
    assign out_link_data   = link_data_r;

`ifdef BJ_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] bht_idx_r;
    logic             upd_en_s;
    logic             unused_fq_s;

    // BHT index of the instruction held in the result register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bht_idx_r <= {IDX_W{1'b0}};
        end else if (load_s) begin
            bht_idx_r <= in_pc[IDX_W+1:2];
        end
    end

    assign upd_en_s    = valid_r & out_ready & !flush & (op_r != OP_INVALID);
    assign unused_fq_s = ^{fq_pc[DATA_W-1:IDX_W+2], fq_pc[1:0]};

    bj_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk       (clk),
        .resetn    (resetn),
        .upd_en    (upd_en_s),
        .upd_idx   (bht_idx_r),
        .upd_taken (taken_r),
        .q_idx     (fq_pc[IDX_W+1:2]),
        .q_taken   (fq_taken)
    );
`else
    localparam int UNUSED_BHT_DEPTH = BHT_DEPTH;

    logic unused_fq_s;

    assign unused_fq_s = ^fq_pc;
    assign fq_taken    = 1'b0;
`endif

endmodule
